// File: rtl/wbs_access_guard.sv
// Requester-side access guard: captures a master cycle, queries the protection checker,
// then forwards to the slave or rejects with err, with a slave watchdog and a violation log.
module wbs_access_guard #(
  parameter int TIMEOUT   = 1000,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbm_cyc_i,
  input  logic                 wbm_stb_i,
  input  logic                 wbm_we_i,
  input  logic [15:0]          wbm_adr_i,
  input  logic [15:0]          wbm_dat_i,
  input  logic [3:0]           wbm_id_i,
  output logic [15:0]          wbm_dat_o,
  output logic                 wbm_ack_o,
  output logic                 wbm_err_o,
  output logic                 vcheck,
  output logic [15:0]          chk_adr,
  output logic                 chk_wr_en,
  output logic [3:0]           chk_wbm_id,
  input  logic                 vpass,
  input  logic                 vfail,
  output logic                 wbs_cyc_o,
  output logic                 wbs_stb_o,
  output logic                 wbs_we_o,
  output logic [15:0]          wbs_adr_o,
  output logic [15:0]          wbs_dat_o,
  input  logic [15:0]          wbs_dat_i,
  input  logic                 wbs_ack_i,
  input  logic                 viol_clr,
  output logic                 viol_valid,
  output logic [15:0]          viol_adr,
  output logic                 viol_we,
  output logic [3:0]           viol_id,
  output logic [CNT_WIDTH-1:0] viol_cnt,
  output logic [CNT_WIDTH-1:0] tout_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FWD} state_t;

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  state_t                r_state;
  logic [15:0]           r_adr;
  logic                  r_we;
  logic [15:0]           r_dat;
  logic [3:0]            r_id;
  logic                  r_vcheck;
  logic                  r_wbs_cyc;
  logic                  r_ack;
  logic                  r_err;
  logic [15:0]           r_rdat;
  logic [WD_W-1:0]       r_wdog;
  logic                  r_viol_valid;
  logic [15:0]           r_viol_adr;
  logic                  r_viol_we;
  logic [3:0]            r_viol_id;
  logic [CNT_WIDTH-1:0]  r_viol_cnt;
  logic [CNT_WIDTH-1:0]  r_tout_cnt;

  logic w_req;
  logic w_viol;
  logic w_tout;

  // The response-cycle gating stops a still-held strobe from restarting the cycle.
  assign w_req  = wbm_cyc_i & wbm_stb_i & ~r_ack & ~r_err;
  assign w_viol = (r_state == S_CHECK) & ~(vpass & ~vfail);
  assign w_tout = (TIMEOUT != 0) & (r_state == S_FWD) & wbm_cyc_i & ~wbs_ack_i &
                  (r_wdog == WD_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_adr     <= '0;
      r_we      <= 1'b0;
      r_dat     <= '0;
      r_id      <= '0;
      r_vcheck  <= 1'b0;
      r_wbs_cyc <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_rdat    <= '0;
      r_wdog    <= '0;
    end else begin
      r_vcheck <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr    <= wbm_adr_i;
            r_we     <= wbm_we_i;
            r_dat    <= wbm_dat_i;
            r_id     <= wbm_id_i;
            r_vcheck <= 1'b1;
            r_state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (vpass & ~vfail) begin
            r_wbs_cyc <= 1'b1;
            r_wdog    <= '0;
            r_state   <= S_FWD;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_FWD: begin
          // Master abort wins over a same-cycle ack or timeout.
          if (!wbm_cyc_i) begin
            r_wbs_cyc <= 1'b0;
            r_state   <= S_IDLE;
          end else if (wbs_ack_i) begin
            r_rdat    <= wbs_dat_i;
            r_ack     <= 1'b1;
            r_wbs_cyc <= 1'b0;
            r_state   <= S_IDLE;
          end else if (w_tout) begin
            r_err     <= 1'b1;
            r_wbs_cyc <= 1'b0;
            r_state   <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear beats a same-cycle capture or increment.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_viol_valid <= 1'b0;
      r_viol_adr   <= '0;
      r_viol_we    <= 1'b0;
      r_viol_id    <= '0;
      r_viol_cnt   <= '0;
      r_tout_cnt   <= '0;
    end else if (viol_clr) begin
      r_viol_valid <= 1'b0;
      r_viol_adr   <= '0;
      r_viol_we    <= 1'b0;
      r_viol_id    <= '0;
      r_viol_cnt   <= '0;
      r_tout_cnt   <= '0;
    end else begin
      if (w_viol) begin
        if (!r_viol_valid) begin
          r_viol_valid <= 1'b1;
          r_viol_adr   <= r_adr;
          r_viol_we    <= r_we;
          r_viol_id    <= r_id;
        end
        if (r_viol_cnt != '1) r_viol_cnt <= r_viol_cnt + 1'b1;
      end
      if (w_tout && (r_tout_cnt != '1)) r_tout_cnt <= r_tout_cnt + 1'b1;
    end
  end

  assign wbm_dat_o  = r_rdat;
  assign wbm_ack_o  = r_ack;
  assign wbm_err_o  = r_err;
  assign vcheck     = r_vcheck;
  assign chk_adr    = r_adr;
  assign chk_wr_en  = r_we;
  assign chk_wbm_id = r_id;
  assign wbs_cyc_o  = r_wbs_cyc;
  assign wbs_stb_o  = r_wbs_cyc;
  assign wbs_we_o   = r_we;
  assign wbs_adr_o  = r_adr;
  assign wbs_dat_o  = r_dat;
  assign viol_valid = r_viol_valid;
  assign viol_adr   = r_viol_adr;
  assign viol_we    = r_viol_we;
  assign viol_id    = r_viol_id;
  assign viol_cnt   = r_viol_cnt;
  assign tout_cnt   = r_tout_cnt;

endmodule

// File: tb/tb_wbs_access_guard.sv
// Scoreboarded bench for wbs_access_guard: directed timing cases plus randomized traffic
// against a transaction-level model of responses and the violation log.
module tb_wbs_access_guard;
  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [15:0] m_adr = '0, m_dat = '0;
  logic [3:0]  m_id = '0;
  logic [15:0] wbm_dat_o;
  logic        wbm_ack_o, wbm_err_o, vcheck, chk_wr_en;
  logic [15:0] chk_adr;
  logic [3:0]  chk_wbm_id;
  logic        vpass, vfail;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o;
  logic [15:0] wbs_adr_o, wbs_dat_o;
  logic [15:0] s_rdat = '0;
  logic        s_ack = 1'b0;
  logic        viol_clr = 1'b0;
  logic        viol_valid, viol_we;
  logic [15:0] viol_adr;
  logic [3:0]  viol_id;
  logic [7:0]  viol_cnt, tout_cnt;

  always #5 clk = ~clk;

  wbs_access_guard #(.TIMEOUT(TOUT), .CNT_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_we_i(m_we), .wbm_adr_i(m_adr),
    .wbm_dat_i(m_dat), .wbm_id_i(m_id), .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o),
    .wbm_err_o(wbm_err_o), .vcheck(vcheck), .chk_adr(chk_adr), .chk_wr_en(chk_wr_en),
    .chk_wbm_id(chk_wbm_id), .vpass(vpass), .vfail(vfail),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack),
    .viol_clr(viol_clr), .viol_valid(viol_valid), .viol_adr(viol_adr), .viol_we(viol_we),
    .viol_id(viol_id), .viol_cnt(viol_cnt), .tout_cnt(tout_cnt)
  );

  int errors = 0;
  int checks = 0;

  // Checker policy: 0 pass, 1 fail, 2 no answer, 3 both asserted.
  int pol = 0;
  assign vpass = vcheck && (pol == 0 || pol == 3);
  assign vfail = vcheck && (pol == 1 || pol == 3);

  // Slave: acks s_delay cycles after the strobe rises; negative means never.
  int          s_delay = 0;
  logic [15:0] s_val = '0;
  int          s_cnt = 0;
  always @(negedge clk) begin
    if (wbs_stb_o) begin
      if (s_delay >= 0 && s_cnt == s_delay) begin
        s_ack  = 1'b1;
        s_rdat = s_val;
      end else begin
        s_ack = 1'b0;
      end
      s_cnt++;
    end else begin
      s_ack = 1'b0;
      s_cnt = 0;
    end
  end

  typedef struct packed {
    logic        is_err;
    logic [15:0] dat;
  } exp_t;
  exp_t exp_q[$];

  // Log model.
  int          m_vcnt = 0, m_tcnt = 0;
  logic        m_valid = 1'b0, m_vwe = 1'b0;
  logic [15:0] m_vadr = '0;
  logic [3:0]  m_vid = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (wbm_ack_o || wbm_err_o)) begin
      checks++;
      if (wbm_ack_o && wbm_err_o) begin
        errors++;
        $display("FAIL ack_err_overlap: ack=1 err=1 expected at most one");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: ack=%0b err=%0b expected no response", wbm_ack_o, wbm_err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_err !== wbm_err_o || (!e.is_err && wbm_dat_o !== e.dat)) begin
          errors++;
          $display("FAIL rsp: err=%0b dat=0x%04h expected err=%0b dat=0x%04h",
                   wbm_err_o, wbm_dat_o, e.is_err, e.dat);
        end else begin
          $display("rsp %s dat=0x%04h", wbm_err_o ? "err" : "ack", wbm_dat_o);
        end
      end
    end
  end

  // One master transaction. ab = number of FWD cycles before the master drops cyc (-1: never).
  task automatic txn(input logic we, input logic [15:0] adr, input logic [15:0] dat,
                     input logic [3:0] id, input int p, input int sd, input int ab,
                     output int vl, output int rl, output int sl,
                     output logic [15:0] ca, output logic cw, output logic [3:0] cid,
                     output logic cyc_after);
    bit pass, abt, done, dropped;
    int endi, nf, drop_t;
    exp_t e;
    pass = (p == 0);
    endi = (sd < 0 || sd > TOUT - 1) ? TOUT - 1 : sd;
    abt  = pass && ab >= 0 && ab <= endi;
    s_val   = 16'($urandom);
    s_delay = sd;
    pol     = p;
    if (!pass) begin
      e.is_err = 1'b1; e.dat = '0; exp_q.push_back(e);
      if (m_vcnt < 255) m_vcnt++;
      if (!m_valid) begin
        m_valid = 1'b1; m_vadr = adr; m_vwe = we; m_vid = id;
      end
    end else if (!abt) begin
      if (sd >= 0 && sd <= TOUT - 1) begin
        e.is_err = 1'b0; e.dat = s_val;
      end else begin
        e.is_err = 1'b1; e.dat = '0;
        if (m_tcnt < 255) m_tcnt++;
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = dat; m_id = id;
    vl = -1; rl = -1; sl = -1; ca = '0; cw = 1'b0; cid = '0; cyc_after = 1'b1;
    nf = 0; done = 0; dropped = 0; drop_t = 0;
    for (int t = 1; t < 60 && !done; t++) begin
      @(negedge clk);
      if (vcheck && vl < 0) begin
        vl = t; ca = chk_adr; cw = chk_wr_en; cid = chk_wbm_id;
      end
      if (wbs_stb_o && sl < 0) sl = t;
      if (dropped) begin
        if (t == drop_t + 1) cyc_after = wbs_cyc_o;
        if (t >= drop_t + 3) done = 1;
      end else if (wbm_ack_o || wbm_err_o) begin
        rl = t; done = 1;
      end else if (wbs_stb_o) begin
        if (nf == ab) begin
          m_cyc = 1'b0; m_stb = 1'b0; dropped = 1; drop_t = t;
        end else begin
          nf++;
        end
      end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    if (!done) chk("txn_bound", 32'd0, 32'd1);
    $display("txn we=%0b adr=0x%04h id=%0h pol=%0d sd=%0d ab=%0d vchk=%0d stb=%0d rsp=%0d",
             we, adr, id, p, sd, ab, vl, sl, rl);
    @(negedge clk);
  endtask

  task automatic clear_log();
    @(negedge clk);
    viol_clr = 1'b1;
    @(negedge clk);
    viol_clr = 1'b0;
    m_vcnt = 0; m_tcnt = 0; m_valid = 1'b0; m_vadr = '0; m_vwe = 1'b0; m_vid = '0;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_viol_valid"}, 32'(viol_valid), 32'(m_valid));
    chk({tag, "_viol_adr"},   32'(viol_adr),   32'(m_vadr));
    chk({tag, "_viol_we"},    32'(viol_we),    32'(m_vwe));
    chk({tag, "_viol_id"},    32'(viol_id),    32'(m_vid));
    chk({tag, "_viol_cnt"},   32'(viol_cnt),   32'(m_vcnt));
    chk({tag, "_tout_cnt"},   32'(tout_cnt),   32'(m_tcnt));
  endtask

  initial begin
    int vl, rl, sl;
    logic [15:0] ca;
    logic cw, cy;
    logic [3:0] cid;
    logic [127:0] outs;

    repeat (3) @(negedge clk);
    outs = {wbm_dat_o, wbm_ack_o, wbm_err_o, vcheck, wbs_cyc_o, wbs_stb_o, wbs_adr_o,
            viol_valid, viol_adr, viol_cnt, tout_cnt};
    chk("reset_outputs", 32'(outs != '0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: read passes, zero-wait slave
    s_val = 16'hBEEF;
    txn(1'b0, 16'h0010, 16'h0, 4'b0001, 0, 0, -1, vl, rl, sl, ca, cw, cid, cy);
    chk("t1_vcheck_cycle", 32'(vl), 32'd1);
    chk("t1_chk_adr", 32'(ca), 32'h0010);
    chk("t1_stb_cycle", 32'(sl), 32'd2);
    chk("t1_ack_cycle", 32'(rl), 32'd3);
    chk("t1_rdata_held", 32'(wbm_dat_o), 32'(s_val));

    // 2: write rejected
    txn(1'b1, 16'h0400, 16'h1234, 4'b0010, 1, 0, -1, vl, rl, sl, ca, cw, cid, cy);
    chk("t2_err_cycle", 32'(rl), 32'd2);
    chk("t2_no_stb", 32'(sl), 32'hFFFF_FFFF);
    chk("t2_chk_wr_id", 32'({cw, cid}), 32'h12);
    chk_log("t2");

    // 3: further rejections keep the first entry; no-answer and both-asserted also reject
    txn(1'b0, 16'h0500, 16'h0, 4'b0100, 2, 0, -1, vl, rl, sl, ca, cw, cid, cy);
    txn(1'b0, 16'h0500, 16'h0, 4'b1000, 3, 0, -1, vl, rl, sl, ca, cw, cid, cy);
    chk_log("t3");
    chk("t3_viol_cnt3", 32'(viol_cnt), 32'd3);
    clear_log();
    chk_log("t3_clr");

    // 4: slave never acks
    txn(1'b0, 16'h0020, 16'h0, 4'b0001, 0, -1, -1, vl, rl, sl, ca, cw, cid, cy);
    chk("t4_timeout_dist", 32'(rl - sl), 32'd16);
    chk("t4_tout_cnt", 32'(tout_cnt), 32'd1);
    chk_log("t4");

    // 5: master abort 3 cycles into the forward phase
    txn(1'b1, 16'h0030, 16'h5555, 4'b0001, 0, -1, 3, vl, rl, sl, ca, cw, cid, cy);
    chk("t5_cyc_dropped", 32'(cy), 32'd0);
    chk("t5_no_rsp", 32'(rl), 32'hFFFF_FFFF);
    txn(1'b0, 16'h0040, 16'h0, 4'b0001, 0, 2, -1, vl, rl, sl, ca, cw, cid, cy);
    chk("t5_next_ack_cycle", 32'(rl), 32'd5);

    // Randomized traffic
    clear_log();
    for (int i = 0; i < 40; i++) begin
      int r, p, sd, ab;
      r  = int'($urandom_range(0, 5));
      p  = (r < 3) ? 0 : r - 2;
      sd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
      txn(1'($urandom), 16'($urandom), 16'($urandom), 4'(1 << $urandom_range(0, 3)),
          p, sd, ab, vl, rl, sl, ca, cw, cid, cy);
    end
    chk_log("rand");

    // 6: saturation
    for (int i = 0; i < 300; i++)
      txn(1'b0, 16'h0600, 16'h0, 4'b0001, 1, 0, -1, vl, rl, sl, ca, cw, cid, cy);
    chk("t6_viol_sat", 32'(viol_cnt), 32'd255);
    chk_log("t6");

    // Asynchronous reset in the middle of a forwarded cycle
    pol = 0; s_delay = -1;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 16'h0700; m_id = 4'b0001;
    for (int t = 0; t < 10 && !wbs_stb_o; t++) @(negedge clk);
    chk("rst_stb_reached", 32'(wbs_stb_o), 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    outs = {wbm_dat_o, wbm_ack_o, wbm_err_o, vcheck, wbs_cyc_o, wbs_stb_o, wbs_adr_o,
            viol_valid, viol_adr, viol_cnt, tout_cnt};
    chk("rst_mid_fwd_outputs", 32'(outs != '0), 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    m_vcnt = 0; m_tcnt = 0; m_valid = 1'b0; m_vadr = '0; m_vwe = 1'b0; m_vid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 16'h0080, 16'h0, 4'b0001, 0, 1, -1, vl, rl, sl, ca, cw, cid, cy);
    chk("post_rst_ack_cycle", 32'(rl), 32'd4);
    chk_log("end");
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
